// File: rtl/aux_port_arbiter.sv
// Arbitrates the single-port aux snapshot RAM between the capture writer and the display reader.
// Define AUX_ARB_STATS_EN to add a saturating conflict counter on conflict_count_out.
module aux_port_arbiter #(
    parameter int DATA_WIDTH        = 16,
    parameter int AUX_ADDRESS_WIDTH = 5,
    parameter int STARVE_LIMIT      = 8
) (
    input  logic                         clock_in,
    input  logic                         reset_in,
    input  logic                         v_blank_in,
    input  logic                         wr_req_in,
    input  logic [AUX_ADDRESS_WIDTH-1:0] wr_address_in,
    input  logic [DATA_WIDTH-1:0]        wr_data_in,
    output logic                         wr_grant_out,
    input  logic                         rd_req_in,
    input  logic [AUX_ADDRESS_WIDTH-1:0] rd_address_in,
    output logic                         rd_grant_out,
    output logic [DATA_WIDTH-1:0]        rd_data_out,
    output logic                         rd_valid_out,
    output logic                         ram_wr_out,
    output logic [AUX_ADDRESS_WIDTH-1:0] ram_address_out,
    output logic [DATA_WIDTH-1:0]        ram_data_out,
    input  logic [DATA_WIDTH-1:0]        ram_data_in
`ifdef AUX_ARB_STATS_EN
    ,
    output logic [15:0]                  conflict_count_out
`endif
);

    localparam int              CW    = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0]   LIMIT = CW'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_READ  = 2'd2
    } state_t;

    state_t                         r_state;
    state_t                         w_next_state;
    logic                           r_v_blank_q;
    logic [CW-1:0]                  r_starve;
    logic                           r_rd_pend;
    logic                           r_rd_valid;
    logic [DATA_WIDTH-1:0]          r_rd_data;
    logic [AUX_ADDRESS_WIDTH-1:0]   r_ram_address;
    logic [DATA_WIDTH-1:0]          r_ram_data;

    logic w_vb_change;
    logic w_forced;
    logic w_writer_wins_tie;
    logic w_lp_req;
    logic w_lp_grant;
    logic w_wr_grant;
    logic w_rd_grant;
    logic w_ram_wr;

    // A level change restarts starvation accounting, so a stale count cannot force the new low side.
    assign w_vb_change       = v_blank_in ^ r_v_blank_q;
    assign w_forced          = (r_starve == LIMIT) && !w_vb_change;
    assign w_writer_wins_tie = v_blank_in ? !w_forced : w_forced;

    // State register: remembers which side was granted last cycle.
    always_ff @(posedge clock_in or posedge reset_in) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (reset_in) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state: the grant decision for this cycle.
    always_comb begin
        // NOTE: default first so no path leaves w_next_state unassigned (no latch).
        w_next_state = ST_IDLE;
        if (wr_req_in && (!rd_req_in || w_writer_wins_tie)) begin
            w_next_state = ST_WRITE;
        end else if (rd_req_in) begin
            w_next_state = ST_READ;
        end
    end

    // Outputs: grants are combinational, RAM strobe decodes the held grant.
    always_comb begin
        w_wr_grant = (w_next_state == ST_WRITE);
        w_rd_grant = (w_next_state == ST_READ);
        w_ram_wr   = (r_state == ST_WRITE);
    end

    assign wr_grant_out = w_wr_grant;
    assign rd_grant_out = w_rd_grant;
    assign ram_wr_out   = w_ram_wr;

    assign w_lp_req   = v_blank_in ? rd_req_in  : wr_req_in;
    assign w_lp_grant = v_blank_in ? w_rd_grant : w_wr_grant;

    always_ff @(posedge clock_in or posedge reset_in) begin
        if (reset_in) begin
            r_v_blank_q <= 1'b0;
            r_starve    <= '0;
        end else begin
            r_v_blank_q <= v_blank_in;
            if (w_vb_change || !w_lp_req || w_lp_grant) begin
                r_starve <= '0;
            end else begin
                r_starve <= r_starve + CW'(1);
            end
        end
    end

    // RAM port registers; address and data hold while idle.
    always_ff @(posedge clock_in or posedge reset_in) begin
        if (reset_in) begin
            r_ram_address <= '0;
            r_ram_data    <= '0;
        end else if (w_wr_grant) begin
            r_ram_address <= wr_address_in;
            r_ram_data    <= wr_data_in;
        end else if (w_rd_grant) begin
            r_ram_address <= rd_address_in;
        end
    end

    assign ram_address_out = r_ram_address;
    assign ram_data_out    = r_ram_data;

    // Read return: address out in N+1, RAM data in N+2, registered at end of N+2.
    always_ff @(posedge clock_in or posedge reset_in) begin
        if (reset_in) begin
            r_rd_pend  <= 1'b0;
            r_rd_valid <= 1'b0;
            r_rd_data  <= '0;
        end else begin
            r_rd_pend  <= (r_state == ST_READ);
            r_rd_valid <= r_rd_pend;
            if (r_rd_pend) begin
                r_rd_data <= ram_data_in;
            end
        end
    end

    assign rd_valid_out = r_rd_valid;
    assign rd_data_out  = r_rd_data;

`ifdef AUX_ARB_STATS_EN
    logic [15:0] r_conflicts;

    always_ff @(posedge clock_in or posedge reset_in) begin
        if (reset_in) begin
            r_conflicts <= '0;
        end else if (wr_req_in && rd_req_in && (r_conflicts != 16'hFFFF)) begin
            r_conflicts <= r_conflicts + 16'd1;
        end
    end

    assign conflict_count_out = r_conflicts;
`endif

endmodule

// File: tb/tb_aux_port_arbiter.sv
// Self-checking bench for aux_port_arbiter: directed scenarios plus randomized traffic
// against a cycle-level reference model of the arbitration rules and RAM contents.
module tb_aux_port_arbiter;

    localparam int DW  = 16;
    localparam int AW  = 5;
    localparam int LIM = 8;

    logic          clock_in = 1'b0;
    logic          reset_in;
    logic          v_blank_in;
    logic          wr_req_in;
    logic [AW-1:0] wr_address_in;
    logic [DW-1:0] wr_data_in;
    logic          wr_grant_out;
    logic          rd_req_in;
    logic [AW-1:0] rd_address_in;
    logic          rd_grant_out;
    logic [DW-1:0] rd_data_out;
    logic          rd_valid_out;
    logic          ram_wr_out;
    logic [AW-1:0] ram_address_out;
    logic [DW-1:0] ram_data_out;
    logic [DW-1:0] ram_data_in;
`ifdef AUX_ARB_STATS_EN
    logic [15:0]   conflict_count_out;
`endif

    aux_port_arbiter #(
        .DATA_WIDTH        (DW),
        .AUX_ADDRESS_WIDTH (AW),
        .STARVE_LIMIT      (LIM)
    ) dut (
        .clock_in        (clock_in),
        .reset_in        (reset_in),
        .v_blank_in      (v_blank_in),
        .wr_req_in       (wr_req_in),
        .wr_address_in   (wr_address_in),
        .wr_data_in      (wr_data_in),
        .wr_grant_out    (wr_grant_out),
        .rd_req_in       (rd_req_in),
        .rd_address_in   (rd_address_in),
        .rd_grant_out    (rd_grant_out),
        .rd_data_out     (rd_data_out),
        .rd_valid_out    (rd_valid_out),
        .ram_wr_out      (ram_wr_out),
        .ram_address_out (ram_address_out),
        .ram_data_out    (ram_data_out),
        .ram_data_in     (ram_data_in)
`ifdef AUX_ARB_STATS_EN
        ,
        .conflict_count_out (conflict_count_out)
`endif
    );

    always #5 clock_in = ~clock_in;

    // Synchronous single-port RAM: one-cycle read latency.
    logic [DW-1:0] ram_mem [32];
    always @(posedge clock_in) begin
        if (ram_wr_out) ram_mem[ram_address_out] <= ram_data_out;
        ram_data_in <= ram_mem[ram_address_out];
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Requester side
    bit            vb;
    bit            wr_pend, rd_pend;
    logic [AW-1:0] wr_a, rd_a;
    logic [DW-1:0] wr_d;

    // Reference model
    int            cyc;
    int            m_cnt;
    bit            m_prev_vb;
    bit            m_ram_wr;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_data;
    logic [DW-1:0] m_mem [32];
    bit            m_known [32];
    bit            exp_v [4];
    bit            exp_k [4];
    logic [DW-1:0] exp_d [4];
    int unsigned   m_conf;

    // Observations of the last cycle
    bit            got_wg, got_rg, got_v;
    logic [DW-1:0] got_d;

    task automatic run_cycle();
        bit change, forced, writer_high, e_wg, e_rg, lp_req, lp_granted;
        int slot;
        v_blank_in    = vb;
        wr_req_in     = wr_pend;
        wr_address_in = wr_a;
        wr_data_in    = wr_d;
        rd_req_in     = rd_pend;
        rd_address_in = rd_a;
        @(negedge clock_in);
        got_wg = wr_grant_out;
        got_rg = rd_grant_out;
        got_v  = rd_valid_out;
        got_d  = rd_data_out;
        slot   = cyc % 4;
        check("ram_wr",   32'(ram_wr_out),      32'(m_ram_wr));
        check("ram_addr", 32'(ram_address_out), 32'(m_addr));
        check("ram_data", 32'(ram_data_out),    32'(m_data));
        check("rd_valid", 32'(rd_valid_out),    32'(exp_v[slot]));
        if (exp_v[slot] && exp_k[slot]) check("rd_data", 32'(rd_data_out), 32'(exp_d[slot]));
        exp_v[slot] = 1'b0;
`ifdef AUX_ARB_STATS_EN
        check("conflicts", 32'(conflict_count_out), m_conf);
        if (wr_pend && rd_pend && m_conf != 32'hFFFF) m_conf++;
`endif
        // The write visible on the RAM port this cycle lands at this cycle's end.
        if (m_ram_wr) begin
            m_mem[m_addr]   = m_data;
            m_known[m_addr] = 1'b1;
        end
        change      = (vb != m_prev_vb);
        forced      = (m_cnt == LIM) && !change;
        writer_high = vb;
        e_wg = 1'b0;
        e_rg = 1'b0;
        if (wr_pend && rd_pend) begin
            if (forced) begin
                e_wg = !writer_high;
                e_rg = writer_high;
            end else begin
                e_wg = writer_high;
                e_rg = !writer_high;
            end
        end else if (wr_pend) e_wg = 1'b1;
        else if (rd_pend) e_rg = 1'b1;
        check("wr_grant", 32'(got_wg), 32'(e_wg));
        check("rd_grant", 32'(got_rg), 32'(e_rg));
        lp_req     = writer_high ? rd_pend : wr_pend;
        lp_granted = writer_high ? e_rg : e_wg;
        if (change || !lp_req || lp_granted) m_cnt = 0;
        else m_cnt++;
        m_prev_vb = vb;
        m_ram_wr  = e_wg;
        if (e_wg) begin
            m_addr = wr_a;
            m_data = wr_d;
        end else if (e_rg) begin
            m_addr = rd_a;
            exp_v[(cyc + 3) % 4] = 1'b1;
            exp_d[(cyc + 3) % 4] = m_mem[rd_a];
            exp_k[(cyc + 3) % 4] = m_known[rd_a];
        end
        if (got_wg) wr_pend = 1'b0;
        if (got_rg) rd_pend = 1'b0;
        @(posedge clock_in);
        #1;
        cyc++;
    endtask

    task automatic apply_reset();
        reset_in  = 1'b1;
        wr_req_in = 1'b0;
        rd_req_in = 1'b0;
        repeat (2) begin
            @(negedge clock_in);
            check("rst_valid",   32'(rd_valid_out),    0);
            check("rst_ram_wr",  32'(ram_wr_out),      0);
            check("rst_address", 32'(ram_address_out), 0);
        end
        @(posedge clock_in);
        #1;
        reset_in  = 1'b0;
        m_cnt     = 0;
        m_prev_vb = 1'b0;
        m_ram_wr  = 1'b0;
        m_addr    = '0;
        m_data    = '0;
        m_conf    = 0;
        for (int i = 0; i < 4; i++) exp_v[i] = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) run_cycle();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int  g_cyc, lat, first_w, seen_valid, rd_next, write_i;
        bit  seen;
        logic [DW-1:0] seen_d;

        reset_in = 1'b1; v_blank_in = 1'b0;
        wr_req_in = 1'b0; rd_req_in = 1'b0;
        wr_address_in = '0; rd_address_in = '0; wr_data_in = '0;
        vb = 1'b0; wr_pend = 1'b0; rd_pend = 1'b0;
        wr_a = '0; rd_a = '0; wr_d = '0;
        cyc = 0;
        for (int i = 0; i < 32; i++) begin
            m_mem[i]   = '0;
            m_known[i] = 1'b0;
        end
        for (int i = 0; i < 4; i++) begin
            exp_k[i] = 1'b0;
            exp_d[i] = '0;
        end
        #3;
        apply_reset();

        // Reset state holds with no requests
        idle(2);
        check("reset_rd_data", 32'(rd_data_out), 0);

        // Read data path: write 1234 to addr 3, read it back
        wr_pend = 1'b1; wr_a = 5'd3; wr_d = 16'h1234;
        run_cycle();
        rd_pend = 1'b1; rd_a = 5'd3;
        g_cyc = cyc;
        run_cycle();
        check("dp_granted", 32'(got_rg), 1);
        seen = 1'b0; lat = 0; seen_d = '0;
        for (int i = 0; i < 8 && !seen; i++) begin
            run_cycle();
            if (got_v) begin
                seen   = 1'b1;
                lat    = cyc - 1 - g_cyc;
                seen_d = got_d;
            end
        end
        check("dp_seen",    32'(seen),   1);
        check("dp_latency", lat,         3);
        check("dp_data",    32'(seen_d), 32'h1234);

        // Blanking, both requesting: 8 writes then 1 forced read, repeating
        vb = 1'b1;
        idle(1);
        for (int i = 0; i < 18; i++) begin
            wr_pend = 1'b1; wr_a = 5'd5; wr_d = 16'hA5A5;
            rd_pend = 1'b1; rd_a = 5'd7;
            run_cycle();
            check("blank_read_slot", 32'(got_rg), 32'(i % 9 == 8));
        end
        wr_pend = 1'b0; rd_pend = 1'b0;
        idle(4);

        // Active video: reader streams 0..9, held writer forced on 9th cycle
        vb = 1'b0;
        idle(1);
        wr_pend = 1'b1; wr_a = 5'd9; wr_d = 16'hBEEF;
        rd_next = 0; write_i = -1;
        for (int i = 0; i < 11; i++) begin
            if (!rd_pend && rd_next < 10) begin
                rd_pend = 1'b1;
                rd_a    = AW'(rd_next);
                rd_next++;
            end
            run_cycle();
            if (got_wg && write_i < 0) write_i = i;
        end
        check("active_forced_write", write_i, 8);
        idle(4);

        // Priority flip: starve count at 5 under blanking, then blanking ends
        vb = 1'b1;
        idle(1);
        for (int i = 0; i < 5; i++) begin
            wr_pend = 1'b1; wr_a = 5'd1; wr_d = 16'h0F0F;
            rd_pend = 1'b1; rd_a = 5'd2;
            run_cycle();
        end
        vb = 1'b0;
        wr_pend = 1'b1; rd_pend = 1'b1;
        run_cycle();
        check("flip_reader_first", 32'(got_rg), 1);
        first_w = -1;
        for (int i = 1; i < 12; i++) begin
            wr_pend = 1'b1; rd_pend = 1'b1;
            run_cycle();
            if (got_wg && first_w < 0) first_w = i;
        end
        check("flip_counter_restart", 32'(first_w >= 8), 1);
        wr_pend = 1'b0; rd_pend = 1'b0;
        idle(4);

        // Reset mid-read: grant, then reset next cycle; no valid may follow
        vb = 1'b0;
        rd_pend = 1'b1; rd_a = 5'd3;
        run_cycle();
        check("mr_granted", 32'(got_rg), 1);
        apply_reset();
        seen_valid = 0;
        for (int i = 0; i < 5; i++) begin
            run_cycle();
            if (got_v) seen_valid++;
        end
        check("mr_no_valid", seen_valid, 0);

`ifdef AUX_ARB_STATS_EN
        apply_reset();
        for (int i = 0; i < 20; i++) begin
            wr_pend = 1'b1; rd_pend = 1'b1; wr_a = 5'd4; rd_a = 5'd6; wr_d = 16'h5555;
            run_cycle();
        end
        wr_pend = 1'b0; rd_pend = 1'b0;
        @(negedge clock_in);
        check("stats_20", 32'(conflict_count_out), 20);
        @(posedge clock_in);
        #1;
        cyc++;
        idle(4);
`endif

        // Randomized traffic with blanking toggles
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 19) == 0) vb = !vb;
            if (!wr_pend && $urandom_range(0, 2) == 0) begin
                wr_pend = 1'b1;
                wr_a    = AW'($urandom_range(0, 31));
                wr_d    = DW'($urandom);
            end
            if (!rd_pend && $urandom_range(0, 1) == 0) begin
                rd_pend = 1'b1;
                rd_a    = AW'($urandom_range(0, 31));
            end
            run_cycle();
        end
        wr_pend = 1'b0; rd_pend = 1'b0;
        idle(5);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
